// File: rtl/inv_sub_text_pkg.sv
// inv_sub_text_pkg: shared constants, FSM encoding and the inverse S-box table for the
// masked inverse substitution layer.
package inv_sub_text_pkg;

    localparam int NIBBLES = 16;
    localparam int RW      = 6;
    // Packed 16x4 table, entry 0 in the top nibble.
    localparam logic [63:0] INV_SBOX = 64'h5EF8_C12D_B463_079A;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

    function automatic int beats(input int lanes);
        return NIBBLES / lanes;
    endfunction

    function automatic int beat_w(input int lanes);
        return (NIBBLES / lanes) > 1 ? $clog2(NIBBLES / lanes) : 1;
    endfunction

    function automatic logic [3:0] inv_sbox_lut(input logic [3:0] x);
        return INV_SBOX[4 * (15 - int'(x)) +: 4];
    endfunction

endpackage

// File: rtl/inv_sub_text_sbox.sv
// inv_sbox: two-share inverse S-box with a two-cycle latency. Both shares are refreshed
// with a common mask, and the table output is re-split with a fresh output mask.
module inv_sbox
    import inv_sub_text_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] Az0,
    input  logic [1:0] Az1,
    input  logic [1:0] Az2,
    input  logic [1:0] Bz0,
    input  logic [1:0] Bz1,
    input  logic [1:0] Bz2,
    input  logic [1:0] Z0,
    input  logic [1:0] Z1,
    input  logic [1:0] Z2,
    output logic [3:0] A_out,
    output logic [3:0] B_out
);
    logic [3:0] a_ref_q, b_ref_q, mask_q, a_out_q, b_out_q;
    logic [3:0] refresh;

    assign refresh = {Az0 ^ Bz1, Bz0 ^ Az1};

    always_ff @(posedge clk) begin
        a_ref_q <= A ^ refresh;
        b_ref_q <= B ^ refresh;
        mask_q  <= {Z0 ^ Az2, Z1 ^ Bz2} ^ {Z2, Z2};
        a_out_q <= inv_sbox_lut(a_ref_q ^ b_ref_q) ^ mask_q;
        b_out_q <= mask_q;
    end

    assign A_out = a_out_q;
    assign B_out = b_out_q;

endmodule

// File: rtl/inv_sub_text.sv
// inv_sub_text: masked inverse substitution over 16 nibbles, serialised across LANES
// inverse S-box instances, with a valid/ready request and result handshake.
module inv_sub_text
    import inv_sub_text_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int SBOX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [95:0] az,
    input  logic [95:0] bz,
    input  logic [95:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] aq,
    output logic [63:0] bq
);
    localparam int NB = beats(LANES);
    localparam int CW = beat_w(LANES);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [63:0]         a_q, b_q, aq_q, bq_q;
    logic [95:0]         az_q, bz_q, z_q;
    logic                in_ready_q, out_valid_q;
    logic [SBOX_LAT-1:0] pv_q;
    logic [CW-1:0]       pk_q [SBOX_LAT];
    logic [3:0]          sa [LANES];
    logic [3:0]          sb [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [3:0] n;
        logic [5:0] ra, rb, rz;
        assign n  = 4'(LANES * int'(cnt_q) + j);
        assign ra = az_q[RW * (15 - int'(n)) +: RW];
        assign rb = bz_q[RW * (15 - int'(n)) +: RW];
        assign rz = z_q[RW * (15 - int'(n)) +: RW];
        inv_sbox u_sbox (
            .clk   (clk),
            .A     (a_q[4 * (15 - int'(n)) +: 4]),
            .B     (b_q[4 * (15 - int'(n)) +: 4]),
            .Az0   (ra[5:4]),
            .Az1   (ra[3:2]),
            .Az2   (ra[1:0]),
            .Bz0   (rb[5:4]),
            .Bz1   (rb[3:2]),
            .Bz2   (rb[1:0]),
            .Z0    (rz[5:4]),
            .Z1    (rz[3:2]),
            .Z2    (rz[1:0]),
            .A_out (sa[j]),
            .B_out (sb[j])
        );
    end

    // The beat index travels alongside the S-box pipeline so write-back knows its nibbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            az_q        <= '0;
            bz_q        <= '0;
            z_q         <= '0;
            aq_q        <= '0;
            bq_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pv_q        <= '0;
            for (int i = 0; i < SBOX_LAT; i++) pk_q[i] <= '0;
        end else begin
            pv_q[0] <= state_q == FEED;
            pk_q[0] <= cnt_q;
            for (int i = 1; i < SBOX_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pk_q[i] <= pk_q[i-1];
            end
            if (pv_q[SBOX_LAT-1]) begin
                for (int j = 0; j < LANES; j++) begin
                    aq_q[4 * (15 - (LANES * int'(pk_q[SBOX_LAT-1]) + j)) +: 4] <= sa[j];
                    bq_q[4 * (15 - (LANES * int'(pk_q[SBOX_LAT-1]) + j)) +: 4] <= sb[j];
                end
            end
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a;
                    b_q        <= b;
                    az_q       <= az;
                    bz_q       <= bz;
                    z_q        <= z;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= FEED;
                end
                FEED: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= cnt_q == LAST ? DRAIN : FEED;
                end
                DRAIN: if (pv_q[SBOX_LAT-1] && pk_q[SBOX_LAT-1] == LAST) begin
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign aq        = aq_q;
    assign bq        = bq_q;

endmodule
